// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 VGA timing constants and receiver lock states,
// shared by the sync generator and the receive-side decoder.
package vga_timing_pkg;

    localparam int H_DISP  = 640;
    localparam int H_RB    = 16;
    localparam int H_RT    = 96;
    localparam int H_LB    = 48;
    localparam int H_TOTAL = H_DISP + H_RB + H_RT + H_LB;

    localparam int V_DISP  = 480;
    localparam int V_BB    = 10;
    localparam int V_RT    = 2;
    localparam int V_TB    = 33;
    localparam int V_TOTAL = V_DISP + V_BB + V_RT + V_TB;

    localparam bit SYNC_POL = 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED,
        CHECK,
        LOCKED
    } rx_state_e;

endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers a sync level on the pixel tick and flags
// its leading and trailing edges for that tick.
module vga_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic level,
    output logic lead,
    output logic trail
);

    logic level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else if (pix_en) begin
            level_d <= level;
        end
    end

    assign lead  = pix_en & level & ~level_d;
    assign trail = pix_en & ~level & level_d;

endmodule

// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: recovers pixel coordinates from a VGA sync/rgb stream
// and locks once a full frame matches the expected timing.
module vga_rx_decoder #(
    parameter int H_DISP   = vga_timing_pkg::H_DISP,
    parameter int H_RB     = vga_timing_pkg::H_RB,
    parameter int H_RT     = vga_timing_pkg::H_RT,
    parameter int H_LB     = vga_timing_pkg::H_LB,
    parameter int V_DISP   = vga_timing_pkg::V_DISP,
    parameter int V_BB     = vga_timing_pkg::V_BB,
    parameter int V_RT     = vga_timing_pkg::V_RT,
    parameter int V_TB     = vga_timing_pkg::V_TB,
    parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic [2:0] rgb_out,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    import vga_timing_pkg::*;

    localparam logic [9:0] H_SPAN_C = 10'(H_LB + H_DISP + H_RB);
    localparam logic [9:0] H_TOT_C  = 10'(H_LB + H_DISP + H_RB + H_RT);
    localparam logic [9:0] V_SPAN_C = 10'(V_TB + V_DISP + V_BB);
    localparam logic [9:0] V_TOT_C  = 10'(V_TB + V_DISP + V_BB + V_RT);
    localparam logic [9:0] H_ACT_LO = 10'(H_LB);
    localparam logic [9:0] H_ACT_HI = 10'(H_LB + H_DISP);
    localparam logic [9:0] V_ACT_LO = 10'(V_TB);
    localparam logic [9:0] V_ACT_HI = 10'(V_TB + V_DISP);

    logic [1:0] rst_pipe;
    logic       rst;

    // asserts with reset, releases two clocks after it drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign rst = rst_pipe[1];

    logic hs_lvl;
    logic vs_lvl;
    logic hs_lead;
    logic hs_trail;
    logic vs_lead;
    logic vs_trail;

    assign hs_lvl = SYNC_POL ? hsync : ~hsync;
    assign vs_lvl = SYNC_POL ? vsync : ~vsync;

    vga_edge_det u_hs_edge (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .level  (hs_lvl),
        .lead   (hs_lead),
        .trail  (hs_trail)
    );

    vga_edge_det u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .level  (vs_lvl),
        .lead   (vs_lead),
        .trail  (vs_trail)
    );

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [9:0] hcnt_inc;
    logic [9:0] vcnt_inc;
    logic [9:0] hcnt_nx;
    logic [9:0] vcnt_nx;
    logic       mismatch;
    logic       active;
    logic       valid_nx;
    rx_state_e  state;

    // *_nx is the position of the sample taken on this tick;
    // hs edge is applied before vs so a vs trail clear wins
    always_comb begin
        hcnt_inc = hcnt;
        if (!(&hcnt)) begin
            hcnt_inc = hcnt + 10'd1;
        end
        hcnt_nx = hs_trail ? 10'd0 : hcnt_inc;

        vcnt_inc = vcnt;
        if (hs_trail && !(&vcnt)) begin
            vcnt_inc = vcnt + 10'd1;
        end
        vcnt_nx = vs_trail ? 10'd0 : vcnt_inc;

        mismatch = (hs_lead  && (hcnt_inc != H_SPAN_C)) ||
                   (hs_trail && (hcnt_inc != H_TOT_C))  ||
                   (vs_lead  && (vcnt_inc != V_SPAN_C)) ||
                   (vs_trail && (vcnt_inc != V_TOT_C));

        active = (hcnt_nx >= H_ACT_LO) && (hcnt_nx < H_ACT_HI) &&
                 (vcnt_nx >= V_ACT_LO) && (vcnt_nx < V_ACT_HI);
    end

    // entry to LOCKED only happens on a vs trail, which is never active
    assign valid_nx = (state == LOCKED) && !mismatch && active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UNLOCKED;
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_valid   <= 1'b0;
            rgb_out     <= 3'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                hcnt        <= hcnt_nx;
                vcnt        <= vcnt_nx;
                pix_x       <= hcnt_nx - H_ACT_LO;
                pix_y       <= vcnt_nx - V_ACT_LO;
                pix_valid   <= valid_nx;
                rgb_out     <= valid_nx ? rgb_in : 3'd0;
                frame_start <= valid_nx && (hcnt_nx == H_ACT_LO) &&
                               (vcnt_nx == V_ACT_LO);
                unique case (state)
                    UNLOCKED: begin
                        if (vs_trail) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (mismatch) begin
                            state    <= UNLOCKED;
                            sync_err <= 1'b1;
                        end else if (vs_trail) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (mismatch) begin
                            state    <= UNLOCKED;
                            locked   <= 1'b0;
                            sync_err <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= UNLOCKED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb_vga_rx_decoder: random-rgb VGA stream with timing faults and resets,
// checked tick by tick against a frame-level reference model.
module tb_vga_rx_decoder;

    localparam int H_DISP = 16;
    localparam int H_RB   = 2;
    localparam int H_RT   = 4;
    localparam int H_LB   = 3;
    localparam int V_DISP = 24;
    localparam int V_BB   = 2;
    localparam int V_RT   = 2;
    localparam int V_TB   = 3;
    localparam int H_TOT  = H_DISP + H_RB + H_RT + H_LB;
    localparam int V_TOT  = V_DISP + V_BB + V_RT + V_TB;
    localparam int HS_BEG = H_DISP + H_RB;
    localparam int HS_END = HS_BEG + H_RT;
    localparam int VS_BEG = V_DISP + V_BB;
    localparam int VS_END = VS_BEG + V_RT;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb_in;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_valid;
    logic [2:0] rgb_out;
    logic       frame_start;
    logic       locked;
    logic       sync_err;

    always #5 clk = ~clk;

    vga_rx_decoder #(
        .H_DISP   (H_DISP),
        .H_RB     (H_RB),
        .H_RT     (H_RT),
        .H_LB     (H_LB),
        .V_DISP   (V_DISP),
        .V_BB     (V_BB),
        .V_RT     (V_RT),
        .V_TB     (V_TB),
        .SYNC_POL (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb_in      (rgb_in),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .rgb_out     (rgb_out),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // reference model: absolute sample/line stamps of sync edges
    int         m_n;
    int         m_last_ht;
    int         m_lines;
    int         m_lines_vt;
    int         m_stage;
    logic       m_hs;
    logic       m_vs;
    logic       e_err;
    logic       e_lock;
    logic       e_valid;
    logic       e_fs;
    logic [2:0] e_rgb;
    int         e_x;
    int         e_y;

    task automatic model_reset();
        m_n        = 0;
        m_last_ht  = 0;
        m_lines    = 0;
        m_lines_vt = 0;
        m_stage    = 0;
        m_hs       = 1'b0;
        m_vs       = 1'b0;
        e_err      = 1'b0;
        e_lock     = 1'b0;
        e_valid    = 1'b0;
        e_fs       = 1'b0;
        e_rgb      = 3'd0;
        e_x        = 0;
        e_y        = 0;
    endtask

    task automatic model_step(input int h, input int v, input logic hs,
                              input logic vs, input logic [2:0] rgb);
        logic mis;
        logic vt;
        m_n++;
        mis = 1'b0;
        if (hs && !m_hs && (m_n - m_last_ht != H_LB + H_DISP + H_RB))
            mis = 1'b1;
        if (!hs && m_hs) begin
            if (m_n - m_last_ht != H_TOT) mis = 1'b1;
            m_last_ht = m_n;
            m_lines++;
        end
        if (vs && !m_vs && (m_lines - m_lines_vt != V_TB + V_DISP + V_BB))
            mis = 1'b1;
        vt = !vs && m_vs;
        if (vt) begin
            if (m_lines - m_lines_vt != V_TOT) mis = 1'b1;
            m_lines_vt = m_lines;
        end
        m_hs  = hs;
        m_vs  = vs;
        e_err = mis && (m_stage != 0);
        if (mis && m_stage != 0) m_stage = 0;
        else if (vt && m_stage < 2) m_stage++;
        e_lock  = (m_stage == 2);
        e_valid = e_lock && (h < H_DISP) && (v < V_DISP);
        e_rgb   = e_valid ? rgb : 3'd0;
        e_fs    = e_valid && (h == 0) && (v == 0);
        e_x     = h;
        e_y     = v;
    endtask

    task automatic tick(input int h, input int v, input logic hs,
                        input logic vs, input logic [2:0] rgb, input int gap);
        @(negedge clk);
        hsync  = hs;
        vsync  = vs;
        rgb_in = rgb;
        pix_en = 1'b1;
        model_step(h, v, hs, vs, rgb);
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        check("sync_err", sync_err, e_err);
        check("locked", locked, e_lock);
        check("pix_valid", pix_valid, e_valid);
        check("rgb_out", rgb_out, e_rgb);
        check("frame_start", frame_start, e_fs);
        if (e_valid) begin
            check("pix_x", pix_x, e_x);
            check("pix_y", pix_y, e_y);
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            check("hold_err", sync_err, 1'b0);
            check("hold_fs", frame_start, 1'b0);
            check("hold_valid", pix_valid, e_valid);
            check("hold_rgb", rgb_out, e_rgb);
            check("hold_lock", locked, e_lock);
        end
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_rgb", rgb_out, 0);
        check("rst_fs", frame_start, 0);
        check("rst_lock", locked, 0);
        check("rst_err", sync_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
    endtask

    task automatic run_frame(input int gap_mode, input int drop_line,
                             input int vs_extra, input int rst_line);
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
        int         gap;
        for (int v = 0; v < V_TOT; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                if (v == drop_line && h == H_DISP + 1) continue;
                if (v == rst_line && h == 5) do_reset();
                hs  = (h >= HS_BEG) && (h < HS_END);
                vs  = (v >= VS_BEG) && (v < VS_END + vs_extra);
                rgb = (h == 10 && v == 20) ? 3'b101
                                           : 3'($urandom_range(0, 7));
                gap = (gap_mode == 2) ? int'($urandom_range(0, 2)) : gap_mode;
                tick(h, v, hs, vs, rgb, gap);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b0;
        rgb_in = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("init_valid", pix_valid, 0);
        check("init_lock", locked, 0);
        check("init_err", sync_err, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        repeat (3) run_frame(0, -1, 0, -1);
        check("s1_locked", locked, 1);

        run_frame(0, 5, 0, -1);
        check("short_line_unlock", locked, 0);
        repeat (3) run_frame(0, -1, 0, -1);
        check("short_line_relock", locked, 1);

        run_frame(0, -1, 1, -1);
        check("long_vs_unlock", locked, 0);
        repeat (3) run_frame(0, -1, 0, -1);
        check("long_vs_relock", locked, 1);

        do_reset();
        run_frame(0, -1, 1, -1);
        repeat (3) run_frame(0, -1, 0, -1);
        check("unlocked_fault_relock", locked, 1);

        run_frame(1, -1, 0, 12);
        check("midreset_check", locked, 0);
        repeat (2) run_frame(1, -1, 0, -1);
        check("midreset_relock", locked, 1);

        repeat (2) run_frame(2, -1, 0, -1);
        check("rand_gap_locked", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
